// File: rtl/gate_exerciser_pkg.sv
// -----------------------------------------------------------------------------
// gate_exerciser_pkg
// Shared types and constants for the gate exerciser:
//   - state_t  : run-sequencer states
//   - MAX_IN   : widest gate supported (also the width of fail_vec)
//   - ERR_W    : width of the saturating mismatch counter
//   - SETTLE_W : width of the settle counter (SETTLE up to 15)
//   - sat_inc  : saturating increment for the mismatch counter
// Build option: none in this file (see gate_exerciser.sv for
// GATE_EXERCISER_STOP_ON_FAIL_EN).
// -----------------------------------------------------------------------------
package gate_exerciser_pkg;

    localparam int MAX_IN   = 3;
    localparam int ERR_W    = 4;
    localparam int SETTLE_W = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Mismatch counter sticks at its maximum instead of wrapping to zero,
    // so a badly broken gate can never look like a clean one.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Down-counter that times how long each input vector is held on the gate
// before its output is sampled.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset, clears the count
//   load      in   load load_val (takes priority over counting)
//   load_val  in   SETTLE_W  value to load
//   en        in   count down by one this cycle (stops at zero)
//   expire    out  current cycle is the last cycle of the settle window
// -----------------------------------------------------------------------------
module settle_timer
    import gate_exerciser_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A count of one means this decrement closes the window; treating zero
    // the same keeps the sequencer from stalling if it is ever entered
    // with an empty counter.
    assign expire = (cnt <= SETTLE_W'(1));

endmodule

// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
// Walks every input vector of a small transistor-level gate, holds each one
// for SETTLE cycles, samples the gate output and compares it against an
// expected truth table latched at the start of the run.
//
// Parameters:
//   NUM_IN  gate inputs, 1..3
//   SETTLE  cycles each vector is held before sampling, 1..15
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   begin a run (only honoured when idle)
//   tt        in   2**NUM_IN  expected truth table, bit k for vector k
//   vec       out  NUM_IN     vector driven onto the gate, bit 0 = input a
//   dut_out   in   gate output; x/z is treated as a mismatch
//   busy      out  run in progress (applying or sampling)
//   done      out  one-cycle pulse when a run completes
//   pass      out  last run had no mismatches; held until next start
//   err_cnt   out  ERR_W  saturating mismatch count
//   fail_vec  out  MAX_IN first mismatching vector (valid when err_cnt != 0)
// Build option:
//   GATE_EXERCISER_STOP_ON_FAIL_EN  end the run at the first mismatch
// -----------------------------------------------------------------------------
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2**NUM_IN-1:0] tt,
    output logic [NUM_IN-1:0]    vec,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [MAX_IN-1:0]    fail_vec
);

    localparam int                  NV        = 2**NUM_IN;
    localparam logic [NUM_IN-1:0]   LAST_VEC  = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    state_t          state;
    state_t          state_nx;
    logic [NV-1:0]   tt_q;
    logic            mismatch;
    logic            stop_now;
    logic            accept;
    logic            record;
    logic            advance;
    logic            finish;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_expire;

    settle_timer u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // Case inequality so a floating or unknown gate output is a failure
    // rather than silently matching either truth-table value.
    assign mismatch = (dut_out !== tt_q[vec]);

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
    assign stop_now = mismatch || (vec == LAST_VEC);
`else
    assign stop_now = (vec == LAST_VEC);
`endif

    assign busy = (state == ST_APPLY) || (state == ST_SAMPLE);

    // ---- sequencer state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---- next state and per-cycle strobes ----
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        record   = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    state_nx = ST_APPLY;
                end
            end
            ST_APPLY: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_nx = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                record = 1'b1;
                if (stop_now) begin
                    state_nx = ST_DONE;
                end else begin
                    advance  = 1'b1;
                    tmr_load = 1'b1;
                    state_nx = ST_APPLY;
                end
            end
            ST_DONE: begin
                finish   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // ---- truth table snapshot (pure data, no reset needed) ----
    // Captured once per run so edits to tt mid-run cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            tt_q <= tt;
        end
    end

    // ---- run results and vector drive ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vec      <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            // done is registered from the DONE state, so it appears one
            // cycle after the last sample and lasts exactly one cycle.
            done <= finish;
            if (accept) begin
                vec      <= '0;
                pass     <= 1'b0;
                err_cnt  <= '0;
                fail_vec <= '0;
            end
            if (record && mismatch) begin
                if (err_cnt == '0) begin
                    fail_vec <= MAX_IN'(vec);
                end
                err_cnt <= sat_inc(err_cnt);
            end
            if (advance) begin
                vec <= vec + 1'b1;
            end
            if (finish) begin
                pass <= (err_cnt == '0);
            end
        end
    end

endmodule
